// File: rtl/ace_pkg.sv
// ACE snoop types shared by the coherency control unit: channel codes,
// CRRESP bit positions and the snoop controller state encoding.
package ace_pkg;

   typedef logic [3:0] acsnoop_t;
   typedef logic [4:0] crresp_t;

   localparam acsnoop_t SnpReadShared = 4'b0001;

   localparam int unsigned CrRespDataTransfer = 0;
   localparam int unsigned CrRespError        = 1;
   localparam int unsigned CrRespPassDirty    = 2;
   localparam int unsigned CrRespIsShared     = 3;
   localparam int unsigned CrRespWasUnique    = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StSnoop = 2'd1,
      StResp  = 2'd2
   } snoopState_e;

endpackage

// File: rtl/ccu_snoop_rr_arb.sv
// Round-robin arbiter: searches from the pointer upward and, on advance,
// moves the pointer to one past the granted index.
module ccu_snoop_rr_arb #(
   parameter  int unsigned NoPorts  = 4,
   localparam int unsigned IdxWidth = (NoPorts > 1) ? $clog2(NoPorts) : 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NoPorts-1:0]  req_i,
   input  logic                advance_i,
   output logic [IdxWidth-1:0] grantIdx_o,
   output logic [NoPorts-1:0]  grantOneHot_o
);

   logic [IdxWidth-1:0] ptr;
   logic                found;
   int unsigned         cand;

   always_comb begin
      found      = 1'b0;
      grantIdx_o = '0;
      cand       = 0;
      for (int unsigned k = 0; k < NoPorts; k++) begin
         cand = 32'(ptr) + k;
         if (cand >= NoPorts) cand = cand - NoPorts;
         if (!found && req_i[IdxWidth'(cand)]) begin
            found      = 1'b1;
            grantIdx_o = IdxWidth'(cand);
         end
      end
      grantOneHot_o = found ? (NoPorts'(1) << grantIdx_o) : '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr <= '0;
      end else if (advance_i) begin
         ptr <= (grantIdx_o == IdxWidth'(NoPorts - 1)) ? '0 : grantIdx_o + 1'b1;
      end
   end

endmodule

// File: rtl/ccu_snoop_ctrl.sv
// Snoop controller: grants one requester, broadcasts the snoop to all other
// ports, ORs their CR responses and returns the aggregate to the initiator.
module ccu_snoop_ctrl
   import ace_pkg::*;
#(
   parameter int unsigned NoPorts   = 4,
   parameter int unsigned AddrWidth = 64
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NoPorts-1:0]           req_valid_i,
   output logic [NoPorts-1:0]           req_ready_o,
   input  logic [NoPorts*AddrWidth-1:0] req_addr_i,
   input  logic [NoPorts*4-1:0]         req_snoop_i,
   output logic [NoPorts-1:0]           resp_valid_o,
   input  logic [NoPorts-1:0]           resp_ready_i,
   output logic [4:0]                   resp_crresp_o,
   output logic [NoPorts-1:0]           ac_valid_o,
   input  logic [NoPorts-1:0]           ac_ready_i,
   output logic [AddrWidth-1:0]         ac_addr_o,
   output logic [3:0]                   ac_snoop_o,
   output logic [2:0]                   ac_prot_o,
   input  logic [NoPorts-1:0]           cr_valid_i,
   output logic [NoPorts-1:0]           cr_ready_o,
   input  logic [NoPorts*5-1:0]         cr_resp_i
);

   localparam int unsigned IdxWidth = (NoPorts > 1) ? $clog2(NoPorts) : 1;

   snoopState_e         state;
   logic [IdxWidth-1:0] grantIdx;
   logic [NoPorts-1:0]  grantOneHot;
   logic [IdxWidth-1:0] initIdx;
   logic [NoPorts-1:0]  initMask;
   logic [NoPorts-1:0]  targetMask;
   logic [NoPorts-1:0]  acDone;
   logic [NoPorts-1:0]  crDone;
   logic [NoPorts-1:0]  acFire;
   logic [NoPorts-1:0]  crFire;
   crresp_t             respAcc;
   crresp_t             crMerge;
   logic                reqFire;
   logic                respFire;

   ccu_snoop_rr_arb #(
      .NoPorts (NoPorts)
   ) uArb (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .req_i         (req_valid_i),
      .advance_i     (reqFire),
      .grantIdx_o    (grantIdx),
      .grantOneHot_o (grantOneHot)
   );

   // req_ready is gated by reset too, since IDLE is also the reset state
   always_comb begin
      initMask      = NoPorts'(1) << initIdx;
      targetMask    = ~initMask;
      req_ready_o   = (rst_ni && state == StIdle) ? grantOneHot : '0;
      reqFire       = |(req_valid_i & req_ready_o);
      ac_valid_o    = (state == StSnoop) ? (targetMask & ~acDone) : '0;
      cr_ready_o    = (state == StSnoop) ? (acDone & ~crDone) : '0;
      acFire        = ac_valid_o & ac_ready_i;
      crFire        = cr_ready_o & cr_valid_i;
      resp_valid_o  = (state == StResp) ? initMask : '0;
      resp_crresp_o = (state == StResp) ? respAcc : '0;
      respFire      = |(resp_valid_o & resp_ready_i);
      ac_prot_o     = 3'b000;
      crMerge       = '0;
      for (int unsigned j = 0; j < NoPorts; j++) begin
         if (crFire[j]) crMerge = crMerge | cr_resp_i[j*5 +: 5];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= StIdle;
         initIdx    <= '0;
         acDone     <= '0;
         crDone     <= '0;
         respAcc    <= '0;
         ac_addr_o  <= '0;
         ac_snoop_o <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (reqFire) begin
                  initIdx    <= grantIdx;
                  ac_addr_o  <= req_addr_i[32'(grantIdx)*AddrWidth +: AddrWidth];
                  ac_snoop_o <= req_snoop_i[32'(grantIdx)*4 +: 4];
                  acDone     <= '0;
                  crDone     <= '0;
                  respAcc    <= '0;
                  state      <= StSnoop;
               end
            end
            StSnoop: begin
               acDone  <= acDone | acFire;
               crDone  <= crDone | crFire;
               respAcc <= respAcc | crMerge;
               // an empty target set completes immediately
               if ((crDone | crFire) == targetMask) state <= StResp;
            end
            StResp: begin
               if (respFire) state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ccu_snoop_ctrl.sv
// Directed bench for the snoop controller: a 4-port and a 1-port instance
// driven through linear steps with hand-computed expectations.
module tb_ccu_snoop_ctrl;
   import ace_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   logic [3:0]   reqValid, reqReady, respValid, respReady;
   logic [3:0]   acValid, acReady, crValid, crReady;
   logic [255:0] reqAddr;
   logic [15:0]  reqSnoop;
   logic [19:0]  crResp;
   logic [4:0]   crresp;
   logic [63:0]  acAddr;
   logic [3:0]   acSnoop;
   logic [2:0]   acProt;

   logic         reqValid1, reqReady1, respValid1, respReady1;
   logic         acValid1, acReady1, crValid1, crReady1;
   logic [63:0]  reqAddr1, acAddr1;
   logic [3:0]   reqSnoop1, acSnoop1;
   logic [4:0]   crResp1, crresp1;
   logic [2:0]   acProt1;

   int nChecks = 0;
   int nPass   = 0;
   int nFail   = 0;
   logic [4:0] expResp;

   always #5 clk = ~clk;

   ccu_snoop_ctrl #(.NoPorts(4), .AddrWidth(64)) u4 (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(reqValid), .req_ready_o(reqReady),
      .req_addr_i(reqAddr), .req_snoop_i(reqSnoop),
      .resp_valid_o(respValid), .resp_ready_i(respReady), .resp_crresp_o(crresp),
      .ac_valid_o(acValid), .ac_ready_i(acReady),
      .ac_addr_o(acAddr), .ac_snoop_o(acSnoop), .ac_prot_o(acProt),
      .cr_valid_i(crValid), .cr_ready_o(crReady), .cr_resp_i(crResp)
   );

   ccu_snoop_ctrl #(.NoPorts(1), .AddrWidth(64)) u1 (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(reqValid1), .req_ready_o(reqReady1),
      .req_addr_i(reqAddr1), .req_snoop_i(reqSnoop1),
      .resp_valid_o(respValid1), .resp_ready_i(respReady1), .resp_crresp_o(crresp1),
      .ac_valid_o(acValid1), .ac_ready_i(acReady1),
      .ac_addr_o(acAddr1), .ac_snoop_o(acSnoop1), .ac_prot_o(acProt1),
      .cr_valid_i(crValid1), .cr_ready_o(crReady1), .cr_resp_i(crResp1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      assert (obs === exp) nPass++;
      else begin
         nFail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Runs the current transaction to completion with every target answering 0.
   task automatic finishTxn(input logic [3:0] expInit);
      acReady = '1;
      crValid = '1;
      crResp  = '0;
      for (int i = 0; i < 20 && respValid == 4'b0; i++) @(negedge clk);
      chk("txnResp", respValid, expInit);
      respReady = '1;
      @(negedge clk);
      acReady   = '0;
      crValid   = '0;
      respReady = '0;
      chk("txnDone", respValid, 4'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      reqValid = '0; reqAddr = '0; reqSnoop = '0; respReady = '0;
      acReady = '0; crValid = '0; crResp = '0;
      reqValid1 = 1'b0; reqAddr1 = '0; reqSnoop1 = '0; respReady1 = 1'b0;
      acReady1 = 1'b0; crValid1 = 1'b0; crResp1 = '0;
      repeat (2) @(negedge clk);

      chk("rstReqReady", reqReady, 4'b0);
      chk("rstAcValid", acValid, 4'b0);
      chk("rstCrReady", crReady, 4'b0);
      chk("rstRespValid", respValid, 4'b0);
      chk("rstCrresp", crresp, 5'b0);
      chk("rstAcAddr", acAddr, 64'h0);
      chk("rstAcSnoop", acSnoop, 4'b0);
      chk("rstU1Resp", respValid1, 1'b0);
      rst_n = 1'b1;

      // ports 0 and 2 together: 0 first, then 2, then 0 back-to-back
      @(negedge clk); reqValid = 4'b0101;
      #1 chk("rrFirst", reqReady, 4'b0001);
      @(negedge clk); reqValid = 4'b0100;
      #1 chk("busyNoGrant", reqReady, 4'b0000);
      finishTxn(4'b0001);
      #1 chk("rrSecond", reqReady, 4'b0100);
      @(negedge clk); reqValid = 4'b0001;
      finishTxn(4'b0100);
      #1 chk("b2bA", reqReady, 4'b0001);
      @(negedge clk);
      finishTxn(4'b0001);
      #1 chk("b2bB", reqReady, 4'b0001);
      @(negedge clk); reqValid = 4'b0000;
      finishTxn(4'b0001);

      // port 1 ReadShared 0x1000, three targets respond
      reqValid = 4'b0010;
      reqAddr[127:64] = 64'h1000;
      reqSnoop[7:4] = SnpReadShared;
      acReady = 4'b1101;
      #1 chk("grantP1", reqReady, 4'b0010);
      @(negedge clk); reqValid = 4'b0000;
      chk("acValidBcast", acValid, 4'b1101);
      chk("acAddr1000", acAddr, 64'h1000);
      chk("acSnoopRS", acSnoop, 4'b0001);
      chk("acProt", acProt, 3'b000);
      chk("crReadyEarly", crReady, 4'b0000);
      @(negedge clk);
      chk("acValidDone", acValid, 4'b0000);
      chk("crReadyAll", crReady, 4'b1101);
      crValid = 4'b1101;
      crResp = {5'b00101, 5'b00000, 5'b00000, 5'b01000};
      @(negedge clk);
      expResp = 5'((1 << CrRespIsShared) | (1 << CrRespPassDirty) | (1 << CrRespDataTransfer));
      chk("respValidP1", respValid, 4'b0010);
      chk("respOr", crresp, expResp);
      chk("crReadyResp", crReady, 4'b0000);
      crValid = '0; acReady = '0; respReady = 4'b0010;
      @(negedge clk); respReady = '0;
      chk("respGone", respValid, 4'b0000);
      chk("crrespZero", crresp, 5'b0);

      // target 3 stalls its AC handshake for 10 cycles
      reqValid = 4'b0010;
      reqAddr[127:64] = 64'hABCD_0000_1234_5678;
      reqSnoop[7:4] = 4'b0111;
      acReady = 4'b0111;
      #1 chk("grantP1again", reqReady, 4'b0010);
      @(negedge clk);
      reqValid = '0; reqAddr = '0; reqSnoop = '0;
      chk("acValidStall0", acValid, 4'b1101);
      crValid = 4'b0101;
      crResp = {5'b00000, 5'b00000, 5'b00000, 5'b10000};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("acValidHold", acValid, 4'b1000);
         chk("acAddrHold", acAddr, 64'hABCD_0000_1234_5678);
         chk("acSnoopHold", acSnoop, 4'b0111);
         chk("crReady3Low", crReady[3], 1'b0);
      end
      acReady = 4'b1000;
      @(negedge clk);
      chk("acValid3Done", acValid, 4'b0000);
      chk("crReady3", crReady, 4'b1000);
      crValid = 4'b1000;
      crResp[19:15] = 5'b00010;
      @(negedge clk);
      expResp = 5'((1 << CrRespWasUnique) | (1 << CrRespError));
      chk("respValidStall", respValid, 4'b0010);
      chk("respOrStall", crresp, expResp);
      crValid = '0; acReady = '0;

      // response back-pressure with another requester pending
      reqValid = 4'b0001;
      reqAddr[63:0] = 64'h2222;
      reqSnoop[3:0] = 4'b1011;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("respHoldValid", respValid, 4'b0010);
         chk("respHoldData", crresp, expResp);
         chk("reqReadyInResp", reqReady, 4'b0000);
         @(negedge clk);
      end
      respReady = 4'b0010;
      @(negedge clk); respReady = '0;
      #1 chk("respReleased", respValid, 4'b0000);
      chk("grantP0", reqReady, 4'b0001);

      // reset pulse in SNOOP with two CRs outstanding
      @(negedge clk); reqValid = '0; acReady = 4'b1110;
      chk("acValidP0", acValid, 4'b1110);
      chk("acAddr2222", acAddr, 64'h2222);
      @(negedge clk);
      chk("crReadyP0", crReady, 4'b1110);
      crValid = 4'b0010;
      @(negedge clk);
      chk("crOutstanding", crReady, 4'b1100);
      rst_n = 1'b0;
      reqValid = 4'b1001;
      #1;
      chk("midRstAcValid", acValid, 4'b0000);
      chk("midRstCrReady", crReady, 4'b0000);
      chk("midRstRespValid", respValid, 4'b0000);
      chk("midRstReqReady", reqReady, 4'b0000);
      chk("midRstAcAddr", acAddr, 64'h0);
      chk("midRstAcSnoop", acSnoop, 4'b0);
      chk("midRstCrresp", crresp, 5'b0);
      @(negedge clk);
      crValid = '0; acReady = '0; rst_n = 1'b1;
      #1 chk("ptrAfterRst", reqReady, 4'b0001);
      @(negedge clk); reqValid = '0;
      finishTxn(4'b0001);

      // single-port instance: no targets, empty response
      reqValid1 = 1'b1; reqAddr1 = 64'h40; reqSnoop1 = SnpReadShared;
      #1 chk("u1Grant", reqReady1, 1'b1);
      @(negedge clk); reqValid1 = 1'b0;
      chk("u1NoAc", acValid1, 1'b0);
      chk("u1NoRespYet", respValid1, 1'b0);
      @(negedge clk);
      chk("u1Resp", respValid1, 1'b1);
      chk("u1Crresp", crresp1, 5'b0);
      chk("u1NoAcResp", acValid1, 1'b0);
      respReady1 = 1'b1;
      @(negedge clk); respReady1 = 1'b0;
      chk("u1Done", respValid1, 1'b0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
